jtframe_pocket_upload: RTL and testbench

// Bridge-read responder for Pocket save/NVRAM upload. Serves APF bridge reads inside
// one address window with core memory data. Fetches bytes through the ioctl read-back

---
 rtl/jtframe_pocket_pkg.sv | 16 +
 rtl/jtframe_pocket_upload_fetch.sv | 91 +++++++++
 rtl/jtframe_pocket_upload.sv | 110 +++++++++++
 tb/tb_jtframe_pocket_upload.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pocket_pkg.sv
// Shared types for the Pocket save/NVRAM upload responder.
package jtframe_pocket_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_CAP
  } fetch_st_t;

  typedef logic [1:0] lane_t;

  // APF bridge reads are big-endian: byte 0 of a word lands in [31:24]
  localparam bit BRIDGE_BE = 1'b1;

endpackage

// File: rtl/jtframe_pocket_upload_fetch.sv
// Byte sequencer for one 32-bit word over the ioctl read-back path.
//   state   | meaning
//   IDLE    | no fetch in flight
//   ADDR    | drive ioctl_addr for lane k
//   WAIT    | let ioctl_din settle (DIN_LAT cycles)
//   CAP     | capture lane k; next lane or finish
module jtframe_pocket_upload_fetch
  import jtframe_pocket_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DIN_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-3:0] start_wa,
  input  logic [7:0]    ioctl_din,
  output logic [24:0]   ioctl_addr,
  output logic          ioctl_ram,
  output logic          busy,
  output logic          done,
  output logic [AW-3:0] wa,
  output logic [31:0]   word
);

  localparam logic [1:0] WAIT_LOAD = 2'(DIN_LAT > 0 ? DIN_LAT - 1 : 0);

  fetch_st_t st, st_nxt;
  lane_t     k;
  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (abort) st_nxt = ST_IDLE;
    else if (start) st_nxt = ST_ADDR;
    else begin
      case (st)
        ST_ADDR: st_nxt = (DIN_LAT == 0) ? ST_CAP : ST_WAIT;
        ST_WAIT: if (cnt == 2'd0) st_nxt = ST_CAP;
        ST_CAP:  st_nxt = (k == 2'd3) ? ST_IDLE : ST_ADDR;
        default: st_nxt = st;
      endcase
    end
  end

  // A restart keeps the old partial word in place; four fresh captures
  // shift it out completely before done can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ioctl_addr <= '0;
      k          <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      wa         <= '0;
      word       <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        ioctl_addr <= '0;
        k          <= '0;
      end else if (start) begin
        wa <= start_wa;
        k  <= '0;
      end else begin
        case (st)
          ST_ADDR: begin
            ioctl_addr <= 25'({wa, k});
            cnt        <= WAIT_LOAD;
          end
          ST_WAIT: cnt <= cnt - 2'd1;
          ST_CAP: begin
            word <= BRIDGE_BE ? {word[23:0], ioctl_din} : {ioctl_din, word[31:8]};
            k    <= k + 2'd1;
            done <= (k == 2'd3);
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (st != ST_IDLE);
  assign ioctl_ram = busy;

endmodule

// File: rtl/jtframe_pocket_upload.sv
// APF bridge-read responder for save/NVRAM upload with a one-word prefetch buffer.
module jtframe_pocket_upload
  import jtframe_pocket_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h2000_0000,
  parameter int          AW      = 16,
  parameter int          DIN_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        rd_busy,
  output logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_din,
  output logic        ioctl_ram
);

  logic          hit;
  logic [AW-3:0] wa, wa_inc;
  logic          buf_vld;
  logic [AW-3:0] buf_addr;
  logic [31:0]   buf_data;
  logic          f_start, f_busy, f_done;
  logic [AW-3:0] f_start_wa, f_wa, f_wa_inc;
  logic [31:0]   f_word;
  logic          unused_addr_lsb;

  assign hit             = bridge_rd & enable & (bridge_addr[31:AW] == BASE[31:AW]);
  assign wa              = bridge_addr[AW-1:2];
  assign wa_inc          = wa + (AW-2)'(1);
  assign f_wa_inc        = f_wa + (AW-2)'(1);
  assign unused_addr_lsb = ^bridge_addr[1:0];

  // Only demand completions chain a prefetch; a finished prefetch just parks.
  always_comb begin
    f_start    = 1'b0;
    f_start_wa = wa;
    if (hit) begin
      if (f_done) begin
        f_start    = 1'b1;
        f_start_wa = (wa == f_wa) ? f_wa_inc : wa;
      end else if (f_busy) begin
        f_start = (wa != f_wa);
      end else begin
        f_start    = 1'b1;
        f_start_wa = (buf_vld && buf_addr == wa) ? wa_inc : wa;
      end
    end else if (f_done && rd_busy) begin
      f_start    = 1'b1;
      f_start_wa = f_wa_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld        <= 1'b0;
      buf_addr       <= '0;
      buf_data       <= '0;
      rd_busy        <= 1'b0;
      bridge_rd_data <= '0;
    end else if (!enable) begin
      buf_vld <= 1'b0;
      rd_busy <= 1'b0;
    end else begin
      if (f_done) begin
        buf_data <= f_word;
        buf_addr <= f_wa;
        buf_vld  <= 1'b1;
      end
      if (hit) begin
        if (f_done && wa == f_wa) begin
          bridge_rd_data <= f_word;
          rd_busy        <= 1'b0;
        end else if (f_busy || f_done) begin
          rd_busy <= 1'b1;
          if (f_busy && wa != f_wa) buf_vld <= 1'b0;
        end else if (buf_vld && buf_addr == wa) begin
          bridge_rd_data <= buf_data;
        end else begin
          rd_busy <= 1'b1;
        end
      end else if (f_done && rd_busy) begin
        bridge_rd_data <= f_word;
        rd_busy        <= 1'b0;
      end
    end
  end

  jtframe_pocket_upload_fetch #(
    .AW      (AW),
    .DIN_LAT (DIN_LAT)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (f_start),
    .abort      (~enable),
    .start_wa   (f_start_wa),
    .ioctl_din  (ioctl_din),
    .ioctl_addr (ioctl_addr),
    .ioctl_ram  (ioctl_ram),
    .busy       (f_busy),
    .done       (f_done),
    .wa         (f_wa),
    .word       (f_word)
  );

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Directed bench for jtframe_pocket_upload; core memory returns offset[7:0] one cycle late.
module tb_jtframe_pocket_upload;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] bridge_addr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        rd_busy;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din = 8'd0;
  logic        ioctl_ram;

  int vectors = 0;
  int errors  = 0;
  logic seen_old = 1'b0;

  jtframe_pocket_upload #(
    .BASE    (32'h2000_0000),
    .AW      (16),
    .DIN_LAT (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .bridge_addr    (bridge_addr),
    .bridge_rd      (bridge_rd),
    .bridge_rd_data (bridge_rd_data),
    .rd_busy        (rd_busy),
    .ioctl_addr     (ioctl_addr),
    .ioctl_din      (ioctl_din),
    .ioctl_ram      (ioctl_ram)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ioctl_din <= ioctl_addr[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bridge_read(input logic [31:0] a);
    @(negedge clk);
    bridge_addr = a;
    bridge_rd   = 1'b1;
    @(negedge clk);
    bridge_rd   = 1'b0;
  endtask

  task automatic wait_busy_fall(output int n);
    n = 0;
    while (rd_busy && n < 100) begin
      @(negedge clk);
      n++;
      if (bridge_rd_data == 32'h4041_4243) seen_old = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ioctl_ram || rd_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [24:0] last;
    logic [24:0] sweep[$];
    logic [31:0] held;

    rst_n       = 1'b0;
    enable      = 1'b1;
    bridge_addr = 32'h0;
    bridge_rd   = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_rd_data", bridge_rd_data, 32'h0);
      check("rst_ioctl_ram", ioctl_ram, 32'h0);
      check("rst_rd_busy", rd_busy, 32'h0);
      bridge_rd   = 1'($urandom_range(0, 1));
      bridge_addr = 32'h2000_0000 | {16'h0, 16'($urandom_range(0, 65535))};
    end
    @(negedge clk);
    bridge_rd = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);

    // demand miss
    bridge_read(32'h2000_0010);
    check("miss_busy_rise", rd_busy, 32'd1);
    wait_busy_fall(lat);
    check("miss_latency", lat, 32'd13);
    check("miss_data", bridge_rd_data, 32'h1011_1213);

    // prefetch sweep of the next word
    last = ioctl_addr;
    for (int i = 0; i < 30 && ioctl_ram; i++) begin
      @(negedge clk);
      if (ioctl_addr != last) begin
        sweep.push_back(ioctl_addr);
        last = ioctl_addr;
      end
    end
    check("pf_count", sweep.size(), 32'd4);
    for (int i = 0; i < 4 && i < sweep.size(); i++)
      check("pf_addr", 32'(sweep[i]), 32'h14 + 32'(i));
    wait_idle();

    // buffer hit
    bridge_read(32'h2000_0014);
    check("hit_data", bridge_rd_data, 32'h1415_1617);
    check("hit_busy0", rd_busy, 32'd0);
    @(negedge clk);
    check("hit_busy1", rd_busy, 32'd0);
    check("hit_pf_addr", 32'(ioctl_addr), 32'h18);
    check("hit_pf_ram", ioctl_ram, 32'd1);
    wait_idle();

    // last word of the window, prefetch wraps
    bridge_read(32'h2000_FFFC);
    wait_busy_fall(lat);
    check("wrap_latency", lat, 32'd13);
    check("wrap_data", bridge_rd_data, 32'hFCFD_FEFF);
    @(negedge clk);
    check("wrap_pf_addr", 32'(ioctl_addr), 32'h0);
    check("wrap_pf_ram", ioctl_ram, 32'd1);
    wait_idle();
    bridge_read(32'h2000_0000);
    check("wrap_hit_data", bridge_rd_data, 32'h0001_0203);
    check("wrap_hit_busy", rd_busy, 32'd0);
    wait_idle();

    // redirect during lane 2
    seen_old = 1'b0;
    bridge_read(32'h2000_0040);
    repeat (7) @(negedge clk);
    check("abort_lane2_addr", 32'(ioctl_addr), 32'h42);
    bridge_read(32'h2000_0080);
    check("abort_busy", rd_busy, 32'd1);
    wait_busy_fall(lat);
    check("abort_latency", lat, 32'd13);
    check("abort_data", bridge_rd_data, 32'h8081_8283);
    check("abort_no_old", seen_old, 32'd0);
    wait_idle();

    // enable drop during lane 1 of a prefetch flushes the buffer
    bridge_read(32'h2000_0084);
    check("en_hit_data", bridge_rd_data, 32'h8485_8687);
    held = bridge_rd_data;
    repeat (4) @(negedge clk);
    check("en_lane1_addr", 32'(ioctl_addr), 32'h89);
    check("en_lane1_ram", ioctl_ram, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_ram", ioctl_ram, 32'd0);
    check("en_off_addr", 32'(ioctl_addr), 32'h0);
    check("en_off_busy", rd_busy, 32'd0);
    check("en_off_data", bridge_rd_data, held);
    enable = 1'b1;
    bridge_read(32'h2000_0084);
    check("en_reread_busy", rd_busy, 32'd1);
    wait_busy_fall(lat);
    check("en_reread_latency", lat, 32'd13);
    check("en_reread_data", bridge_rd_data, 32'h8485_8687);
    wait_idle();

    // outside the window
    held = bridge_rd_data;
    bridge_read(32'h3000_0000);
    for (int i = 0; i < 5; i++) begin
      check("out_ram", ioctl_ram, 32'd0);
      check("out_busy", rd_busy, 32'd0);
      @(negedge clk);
    end
    check("out_data", bridge_rd_data, held);

    // async reset in the middle of a fetch
    bridge_read(32'h2000_0200);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", bridge_rd_data, 32'h0);
    check("arst_busy", rd_busy, 32'd0);
    check("arst_ram", ioctl_ram, 32'd0);
    check("arst_addr", 32'(ioctl_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
